// File: rtl/cbx_io_bank_cfg_seq_pkg.sv
// Shared types and constants for the CBX+IO config-bank programming sequencer.
package cbx_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } cfg_state_e;

    // Counter holds WL_PULSE-1 down to 0, so clog2(WL_PULSE) bits suffice.
    function automatic int pulse_cnt_width(input int pulse);
        return (pulse > 1) ? $clog2(pulse) : 1;
    endfunction

    localparam logic RST_READY = 1'b1;
    localparam logic RST_ERR   = 1'b0;
    localparam logic RST_DONE  = 1'b0;

endpackage

// File: rtl/cbx_io_bank_cfg_seq_wl_decoder.sv
// Binary wordline index to one-hot wordline vector; disabled or out-of-range gives zero.
module cbx_wl_decoder #(
    parameter int WL_COUNT = 10,
    parameter int AW       = 4
) (
    input  logic                en,
    input  logic [AW-1:0]       addr,
    output logic [WL_COUNT-1:0] wl
);

    generate
        for (genvar gi = 0; gi < WL_COUNT; gi++) begin : g_row
            assign wl[gi] = en && (int'(addr) == gi);
        end
    endgenerate

endmodule

// File: rtl/cbx_io_bank_cfg_seq.sv
// Config-frame sequencer: writes pulse one wordline for WL_PULSE cycles behind a
// bitline setup cycle, reads come back from a shadow copy of the bank.
module cbx_io_bank_cfg_seq
    import cbx_cfg_pkg::*;
#(
    parameter int  BL_WIDTH = 8,
    parameter int  WL_COUNT = 10,
    parameter int  WL_PULSE = 2,
    localparam int AW       = (WL_COUNT > 1) ? $clog2(WL_COUNT) : 1
) (
    input  logic                prog_clk,
    input  logic                prog_rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic                cfg_rd,
    input  logic                cfg_auto,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [BL_WIDTH-1:0] cfg_data,
    output logic                rd_valid,
    output logic [BL_WIDTH-1:0] rd_data,
    output logic [BL_WIDTH-1:0] bl,
    output logic [WL_COUNT-1:0] wl,
    output logic                cfg_err,
    output logic                cfg_done
);

    localparam int            CW         = pulse_cnt_width(WL_PULSE);
    localparam logic [CW-1:0] PULSE_LAST = CW'(WL_PULSE - 1);
    localparam logic [AW-1:0] ADDR_MAX   = AW'(WL_COUNT - 1);

    cfg_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  auto_q, auto_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [BL_WIDTH-1:0]   bl_q, bl_d;
    logic [WL_COUNT-1:0]   written_q, written_d;
    logic [BL_WIDTH-1:0]   shadow_q [WL_COUNT];
    logic [BL_WIDTH-1:0]   shadow_d [WL_COUNT];
    logic                  rd_valid_q, rd_valid_d;
    logic [BL_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic [AW-1:0]         eff_addr;
    logic                  in_range;
    logic                  wr_go;
    logic                  rd_go;
    logic                  bad_go;
    logic                  pulse_end;
    logic                  wl_en;

    always_comb begin
        accept    = cfg_valid && (state_q == ST_IDLE);
        eff_addr  = cfg_auto ? ptr_q : cfg_addr;
        in_range  = int'(eff_addr) < WL_COUNT;
        wr_go     = accept && !cfg_rd && in_range;
        rd_go     = accept &&  cfg_rd && in_range;
        bad_go    = accept && !in_range;
        pulse_end = (state_q == ST_PULSE) && (cnt_q == '0);
    end

    // State register.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (wr_go) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_PULSE;
            ST_PULSE: if (cnt_q == '0) state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; wl follows state_q so reset drops it immediately.
    always_comb begin
        cfg_ready = (state_q == ST_IDLE);
        wl_en     = (state_q == ST_PULSE);
    end

    cbx_wl_decoder #(
        .WL_COUNT (WL_COUNT),
        .AW       (AW)
    ) u_wl_dec (
        .en   (wl_en),
        .addr (addr_q),
        .wl   (wl)
    );

    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        auto_d     = auto_q;
        bl_d       = bl_q;
        ptr_d      = ptr_q;
        written_d  = written_q;
        shadow_d   = shadow_q;
        rd_valid_d = rd_go;
        rd_data_d  = rd_data_q;
        err_d      = err_q || bad_go;
        done_d     = done_q;

        if (wr_go) begin
            bl_d   = cfg_data;
            addr_d = eff_addr;
            auto_d = cfg_auto;
        end
        if (rd_go) begin
            rd_data_d = shadow_q[eff_addr];
        end
        if (state_q == ST_SETUP) begin
            cnt_d = PULSE_LAST;
        end else if ((state_q == ST_PULSE) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        // Commit to the shadow copy on the edge that enters HOLD.
        if (pulse_end) begin
            shadow_d[addr_q]  = bl_q;
            written_d[addr_q] = 1'b1;
        end
        if (state_q == ST_HOLD) begin
            done_d = done_q || (&written_q);
            if (auto_q) begin
                ptr_d = (ptr_q == ADDR_MAX) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            auto_q     <= 1'b0;
            bl_q       <= '0;
            ptr_q      <= '0;
            written_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= RST_ERR;
            done_q     <= RST_DONE;
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            auto_q     <= auto_d;
            bl_q       <= bl_d;
            ptr_q      <= ptr_d;
            written_q  <= written_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < WL_COUNT; gi++) begin : g_shadow
            always_ff @(posedge prog_clk or negedge prog_rst_n) begin
                if (!prog_rst_n) begin
                    shadow_q[gi] <= '0;
                end else begin
                    shadow_q[gi] <= shadow_d[gi];
                end
            end
        end
    endgenerate

    assign bl       = bl_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign cfg_err  = err_q;
    assign cfg_done = done_q;

endmodule

// File: tb/tb_cbx_io_bank_cfg_seq.sv
// Directed plus randomized frames against a behavioural bank model; immediate assertions at every check.
module tb_cbx_io_bank_cfg_seq;

    localparam int BLW = 8;
    localparam int WLC = 10;
    localparam int WLP = 2;
    localparam int AW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           cfg_valid, cfg_rd, cfg_auto;
    logic [AW-1:0]  cfg_addr;
    logic [BLW-1:0] cfg_data;
    logic           cfg_ready, rd_valid, cfg_err, cfg_done;
    logic [BLW-1:0] rd_data, bl;
    logic [WLC-1:0] wl;

    logic           rst3_n;
    logic           v3, rd3, auto3;
    logic [AW-1:0]  addr3;
    logic [BLW-1:0] data3;
    logic           ready3, rd_valid3, err3, done3;
    logic [BLW-1:0] rd_data3, bl3;
    logic [WLC-1:0] wl3;

    cbx_io_bank_cfg_seq #(.BL_WIDTH(BLW), .WL_COUNT(WLC), .WL_PULSE(WLP)) u_dut (
        .prog_clk(clk), .prog_rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_rd(cfg_rd), .cfg_auto(cfg_auto), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .bl(bl), .wl(wl),
        .cfg_err(cfg_err), .cfg_done(cfg_done)
    );

    cbx_io_bank_cfg_seq #(.BL_WIDTH(BLW), .WL_COUNT(WLC), .WL_PULSE(3)) u_dut3 (
        .prog_clk(clk), .prog_rst_n(rst3_n), .cfg_valid(v3), .cfg_ready(ready3),
        .cfg_rd(rd3), .cfg_auto(auto3), .cfg_addr(addr3), .cfg_data(data3),
        .rd_valid(rd_valid3), .rd_data(rd_data3), .bl(bl3), .wl(wl3),
        .cfg_err(err3), .cfg_done(done3)
    );

    int checks = 0;
    int errors = 0;

    logic [BLW-1:0] m_shadow [WLC];
    bit             m_written [WLC];
    int             m_ptr;
    bit             m_err, m_done;
    logic [BLW-1:0] prev_bl;
    logic [WLC-1:0] prev_wl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inv();
        chk("wl_onehot0", 32'($onehot0(wl)), 32'd1);
        if (prev_wl != '0 && wl != '0) chk("bl_stable", 32'(bl), 32'(prev_bl));
        prev_bl = bl;
        prev_wl = wl;
    endtask

    task automatic model_reset();
        for (int i = 0; i < WLC; i++) begin
            m_shadow[i]  = '0;
            m_written[i] = 1'b0;
        end
        m_ptr  = 0;
        m_err  = 1'b0;
        m_done = 1'b0;
        prev_bl = '0;
        prev_wl = '0;
    endtask

    task automatic drive(input bit rd, input bit au, input int addr, input logic [BLW-1:0] data);
        cfg_rd    = rd;
        cfg_auto  = au;
        cfg_addr  = AW'(addr);
        cfg_data  = data;
        cfg_valid = 1'b1;
    endtask

    // Called just after the accepting edge; checks every cycle until the frame completes.
    task automatic frame_tail(input bit rd, input bit au, input int addr, input logic [BLW-1:0] data);
        int             eff;
        logic [WLC-1:0] exp_wl;
        bit             all_w;
        eff = au ? m_ptr : addr;
        if (eff >= WLC) begin
            m_err = 1'b1;
            @(negedge clk); inv();
            chk("oor_ready", 32'(cfg_ready), 32'd1);
            chk("oor_wl", 32'(wl), 32'd0);
            chk("oor_rdv", 32'(rd_valid), 32'd0);
        end else if (rd) begin
            @(negedge clk); inv();
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", 32'(rd_data), 32'(m_shadow[eff]));
            chk("rd_ready", 32'(cfg_ready), 32'd1);
        end else begin
            exp_wl      = '0;
            exp_wl[eff] = 1'b1;
            @(negedge clk); inv();
            chk("setup_bl", 32'(bl), 32'(data));
            chk("setup_wl", 32'(wl), 32'd0);
            chk("setup_ready", 32'(cfg_ready), 32'd0);
            for (int p = 0; p < WLP; p++) begin
                @(negedge clk); inv();
                chk("pulse_wl", 32'(wl), 32'(exp_wl));
                chk("pulse_bl", 32'(bl), 32'(data));
                chk("pulse_ready", 32'(cfg_ready), 32'd0);
            end
            @(negedge clk); inv();
            chk("hold_wl", 32'(wl), 32'd0);
            chk("hold_bl", 32'(bl), 32'(data));
            chk("hold_ready", 32'(cfg_ready), 32'd0);
            m_shadow[eff]  = data;
            m_written[eff] = 1'b1;
            if (au) m_ptr = (m_ptr + 1) % WLC;
            all_w = 1'b1;
            for (int i = 0; i < WLC; i++) all_w &= m_written[i];
            m_done = m_done | all_w;
            @(negedge clk); inv();
            chk("idle_ready", 32'(cfg_ready), 32'd1);
            chk("idle_wl", 32'(wl), 32'd0);
            chk("idle_bl", 32'(bl), 32'(data));
        end
        chk("err", 32'(cfg_err), 32'(m_err));
        chk("done", 32'(cfg_done), 32'(m_done));
    endtask

    task automatic do_frame(input bit rd, input bit au, input int addr, input logic [BLW-1:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) chk("ready_timeout", 32'(cfg_ready), 32'd1);
        drive(rd, au, addr, data);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        frame_tail(rd, au, addr, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        cfg_valid = 1'b0; cfg_rd = 1'b0; cfg_auto = 1'b0; cfg_addr = '0; cfg_data = '0;
        v3 = 1'b0; rd3 = 1'b0; auto3 = 1'b0; addr3 = '0; data3 = '0;
        model_reset();
        #22;
        chk("rst_bl", 32'(bl), 32'd0);
        chk("rst_wl", 32'(wl), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_rdd", 32'(rd_data), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;

        // Reset in the middle of a 3-cycle pulse on the second instance.
        @(negedge clk);
        v3 = 1'b1; rd3 = 1'b0; auto3 = 1'b0; addr3 = 4'd4; data3 = 8'h3C;
        @(posedge clk);
        #1 v3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r3_pulse_wl", 32'(wl3), 32'h10);
        #1 rst3_n = 1'b0;
        #1;
        chk("r3_async_wl", 32'(wl3), 32'd0);
        chk("r3_async_bl", 32'(bl3), 32'd0);
        chk("r3_ready", 32'(ready3), 32'd1);
        chk("r3_err", 32'(err3), 32'd0);
        chk("r3_done", 32'(done3), 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        @(negedge clk);
        v3 = 1'b1; rd3 = 1'b1; addr3 = 4'd4;
        @(posedge clk);
        #1 v3 = 1'b0;
        @(negedge clk);
        chk("r3_rdv", 32'(rd_valid3), 32'd1);
        chk("r3_rdd", 32'(rd_data3), 32'd0);

        // Explicit write then readback.
        do_frame(1'b0, 1'b0, 3, 8'hA5);
        do_frame(1'b1, 1'b0, 3, 8'h00);
        chk("rd3_a5", 32'(rd_data), 32'hA5);

        // Out-of-range write, then a normal write.
        do_frame(1'b0, 1'b0, 12, 8'hEE);
        chk("oor_err_const", 32'(cfg_err), 32'd1);
        do_frame(1'b0, 1'b0, 7, 8'h77);

        // Auto stream covering every row, then one wrap.
        for (int i = 0; i < WLC; i++) begin
            if (i == WLC - 1) chk("done_pre", 32'(cfg_done), 32'd0);
            do_frame(1'b0, 1'b1, 0, 8'(8'h10 + i));
        end
        chk("done_post", 32'(cfg_done), 32'd1);
        do_frame(1'b0, 1'b1, 0, 8'h55);

        // Back-to-back reads on consecutive cycles.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, i, 8'h00);
            @(posedge clk);
            @(negedge clk); inv();
            chk("b2b_rdv", 32'(rd_valid), 32'd1);
            chk("b2b_rdd", 32'(rd_data), 32'(m_shadow[i]));
        end
        cfg_valid = 1'b0;

        // cfg_valid held high across a write: next frame accepted on the IDLE return edge.
        @(negedge clk);
        drive(1'b0, 1'b0, 5, 8'h5A);
        @(posedge clk);
        #1 cfg_addr = 4'd6; cfg_data = 8'h6B;
        frame_tail(1'b0, 1'b0, 5, 8'h5A);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        frame_tail(1'b0, 1'b0, 6, 8'h6B);

        // Randomized frames.
        for (int k = 0; k < 40; k++) begin
            do_frame($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
